serial_adder_ctrl: RTL

Bit-serial add/subtract controller that time-shares one 1-bit full-adder cell across WIDTH-bit operands.
- Latches operands on a start handshake.
- Feeds one bit pair plus the registered carry to the cell per clock, LSB first, and shifts sum bits into a result register.
- Reports carry, signed overflow and zero with a done pulse.
- Sits between the lab's operand switches/control FSM and the 1-bit adder cell. It is the sequencer that turns that cell into a multi-bit ALU slice.

---
 rtl/serial_adder_ctrl_pkg.sv | 21 ++
 rtl/full_adder_1b.sv | 20 ++
 rtl/serial_adder_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// ============================================================================
// serial_adder_ctrl_pkg : shared state encoding and default sizing
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 5;

    // Encoding 2'd3 is unused; the controller steers it back to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/full_adder_1b.sv
// ============================================================================
// full_adder_1b : single-bit full adder cell time-shared by the controller
// Rev 1.0
// ============================================================================
`default_nettype none

module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// serial_adder_ctrl : LSB-first bit-serial add/subtract sequencer around one
//                     full-adder cell; reports carry, signed overflow, zero
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic               fa_s;
    logic               fa_co;
    logic [WIDTH-1:0]   sum_shift;
    logic               last_bit;

    full_adder_1b u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Sum bits arrive LSB first, so they enter from the MSB end.
    assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B and force carry-in.
                    a_d     = a_in;
                    b_d     = sub ? ~b_in : b_in;
                    carry_d = sub | cin;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d   = sum_shift;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // carry_q here is the carry into the MSB.
                    ovf_d   = carry_q ^ fa_co;
                    cout_d  = fa_co;
                    zero_d  = (sum_shift == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q == S_RUN) || (state_q == S_DONE);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

`default_nettype wire
